uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive-side counterpart of the team's UART transmitter and shares its CLK_FREQ/BAUD_RATE parameterisation.
- Synchronises the asynchronous serial line, detects the start bit, samples each bit at its midpoint using a baud divider, and presents one byte per frame with a single-cycle valid strobe.
- Sits between the board RX pin and the command/data consumer logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- Derived localparam BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division).
- Derived localparam HALF_DIV = BAUD_DIV / 2.
- BAUD_DIV must be at least 4. The divider counter is 16 bits wide.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last correctly received byte; holds its value until the next good frame.
- rx_valid  output  1  one-cycle pulse when data_out is updated.
- rx_busy  output  1  high from start-bit detection until the frame completes.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; nothing is sampled asynchronously except rx, which passes through the 2-FF synchroniser.
- Reset values: data_out=0, rx_valid=0, rx_busy=0, frame_err=0, state=IDLE, synchroniser flops=1, counters=0. Reset mid-frame abandons the frame with no pulse.
- Synchroniser: rx_s = rx delayed by 2 clk. All decisions use rx_s only.
- IDLE:
  - rx_busy=0.
  - If rx_s==0: go to START, baud_cnt=0, rx_busy=1.
- START:
  - Count baud_cnt up to HALF_DIV-1.
  - At HALF_DIV-1: if rx_s==0, go to DATA with baud_cnt=0, bit_cnt=0. Otherwise it is a glitch: go to IDLE, rx_busy=0, no pulse.
- DATA:
  - Count baud_cnt up to BAUD_DIV-1.
  - At BAUD_DIV-1: shift_reg = {rx_s, shift_reg[7:1]} (LSB first), baud_cnt=0.
  - After the 8th sample (bit_cnt==7): go to STOP (or PARITY, see Optional Feature).
- STOP:
  - Count to BAUD_DIV-1, then sample rx_s.
  - rx_s==1: data_out=shift_reg, rx_valid=1 for one cycle, go to IDLE, rx_busy=0.
  - rx_s==0: frame_err=1 for one cycle, data_out unchanged, go to BREAK.
- BREAK:
  - Remain while rx_s==0, with rx_busy held high.
  - On rx_s==1: go to IDLE, rx_busy=0.
  - Prevents a held-low line from being read as back-to-back 0x00 frames.
- rx_valid and frame_err are never high in the same cycle. Neither is ever high for more than 1 cycle.
- Latency: the stop sample, and hence the rx_valid edge, occurs 2 + HALF_DIV + 9*BAUD_DIV clk (±1) after rx falls.
- A new start bit arriving immediately after a good stop sample is accepted: IDLE checks rx_s on the next cycle.
- No input buffering. The consumer must capture data_out on rx_valid; it is held until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An extra PARITY state between DATA and STOP samples one bit after the 8 data bits.
  - Even parity is required: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: after the stop bit is sampled high, raise output parity_err (1 bit, one-cycle pulse) instead of rx_valid; data_out unchanged.
  - A stop-bit failure still gives frame_err only.
  - Frame is 11 bit periods; latency gains BAUD_DIV.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg holds:
  - state encoding shared with the transmitter: IDLE, START, DATA, PARITY, STOP, BREAK (3 bits);
  - UART_DATA_W=8;
  - BAUD_CNT_W=16.
- Sub-module uart_sync: 2-FF synchroniser, reset value 1, reusable for other async inputs.
- All FSM and datapath logic stays in uart_rx.

Test Plan (CLK_FREQ=1600, BAUD_RATE=100, so BAUD_DIV=16 and HALF_DIV=8):
- Drive 0xA5 as an 8N1 frame, 16 clk per bit.
  - Expect data_out=0xA5 with a single rx_valid pulse at 2+8+144 clk (±1) after the start edge.
  - Expect rx_busy high throughout, frame_err never high.
- Send 0x00, then 0xFF back-to-back with no idle gap.
  - Expect two rx_valid pulses with data_out 0x00 then 0xFF.
- Pulse rx low for 4 clk, then return high.
  - Expect no rx_valid, rx_busy back to 0 by 14 clk after the edge, state IDLE.
- Send 0x3C with the stop bit low, and hold rx low for 100 clk.
  - Expect one frame_err pulse, data_out still at its previous value, rx_busy high until rx returns high.
  - Then send 0x81: data_out=0x81 with rx_valid.
- Assert rst for 1 clk in the middle of bit 4 of a frame.
  - Expect all outputs at reset values on the next cycle and no pulse from that frame.
  - Then send 0x5A: received correctly.
- With UART_RX_PARITY_EN defined, send 0x07 with parity bit 1 (good).
  - Expect rx_valid and data_out=0x07.
- With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 (bad).
  - Expect a parity_err pulse and no rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, datapath widths and parity helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned BAUD_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  // True when data bits plus the received parity bit have even weight.
  function automatic logic even_parity_ok(input logic [UART_DATA_W-1:0] data,
                                          input logic                   par);
    return (^{data, par}) == 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer bundle. Optional UART_RX_PARITY_EN adds parity_err.
interface uart_rx_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] data_out;
  logic                   rx_valid;
  logic                   rx_busy;
  logic                   frame_err;
`ifdef UART_RX_PARITY_EN
  logic                   parity_err;
`endif

`ifdef UART_RX_PARITY_EN
  modport master (output data_out, output rx_valid, output rx_busy, output frame_err,
                  output parity_err);
  modport slave  (input  data_out, input  rx_valid, input  rx_busy, input  frame_err,
                  input  parity_err);
`else
  modport master (output data_out, output rx_valid, output rx_busy, output frame_err);
  modport slave  (input  data_out, input  rx_valid, input  rx_busy, input  frame_err);
`endif

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to RESET_VAL.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {2{RESET_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and break hold-off.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(HALF_DIV - 1);

  generate
    if (BAUD_DIV < 4) begin : g_bad_div
      $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic rx_s;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  uart_state_e            state_q,    state_d;
  logic [BAUD_CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]             bit_cnt_q,  bit_cnt_d;
  logic [UART_DATA_W-1:0] shift_q,    shift_d;
  logic [UART_DATA_W-1:0] data_q,     data_d;
  logic                   valid_q,    valid_d;
  logic                   busy_q,     busy_d;
  logic                   ferr_q,     ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_ok_q,   par_ok_d;
  logic                   perr_q,     perr_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ok_d   = par_ok_q;
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        busy_d     = 1'b0;
        baud_cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
          busy_d  = 1'b1;
        end
      end

      // Mid-start-bit recheck rejects short glitches.
      START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[UART_DATA_W-1:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          par_ok_d   = even_parity_ok(shift_q, rx_s);
          state_d    = STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_CNT_W'(1);
        end
      end
`endif

      STOP: begin
        if (baud_cnt_q == BAUD_LAST) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            if (par_ok_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              perr_d  = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_CNT_W'(1);
        end
      end

      // Wait out a held-low line so it is not read as a stream of 0x00 frames.
      BREAK: begin
        busy_d = 1'b1;
        if (rx_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_ok_q   <= par_ok_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a scoreboard of expected output pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ  = 1600;
  localparam int unsigned BAUD_RATE = 100;
  localparam int          BIT_CLK   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int          LAT_NOM   = 2 + 8 + 10 * 16;
`else
  localparam int          LAT_NOM   = 2 + 8 + 9 * 16;
`endif

  typedef enum logic [1:0] {EV_VALID = 2'd0, EV_FERR = 2'd1, EV_PERR = 2'd2} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   t_drop = 0;
  int   last_valid_cyc = -1;
  logic [7:0] last_good = 8'h00;
  ev_t  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  logic     prev_valid = 1'b0;
  logic     prev_ferr  = 1'b0;
  logic     prev_perr  = 1'b0;
  logic     cur_perr;
  ev_kind_e obs_kind;
  ev_t      exp_ev;

  always @(negedge clk) begin
    cur_perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    cur_perr = bus.parity_err;
`endif
    if (!rst && (bus.rx_valid || bus.frame_err || cur_perr)) begin
      obs_kind = bus.rx_valid ? EV_VALID : (bus.frame_err ? EV_FERR : EV_PERR);
      check("pulse_exclusive", 16'(bus.rx_valid + bus.frame_err + cur_perr), 16'd1);
      check("pulse_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) begin
        exp_ev = exp_q.pop_front();
        check("pulse_kind", 16'(obs_kind), 16'(exp_ev.kind));
        check("pulse_data_out", 16'(bus.data_out), 16'(exp_ev.data));
      end
      if (bus.rx_valid) begin
        last_valid_cyc = cyc;
        check("valid_single_cycle", 16'(prev_valid), 16'd0);
      end
      if (bus.frame_err) check("ferr_single_cycle", 16'(prev_ferr), 16'd0);
      if (cur_perr)      check("perr_single_cycle", 16'(prev_perr), 16'd0);
    end
    prev_valid = bus.rx_valid;
    prev_ferr  = bus.frame_err;
    prev_perr  = cur_perr;
  end

  // Drives one frame; optionally checks rx_busy at every bit midpoint.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic par_bit, input bit chk_busy);
    logic [10:0] bits;
    int          nbits;
`ifdef UART_RX_PARITY_EN
    bits  = {stop_bit, par_bit, d, 1'b0};
    nbits = 11;
`else
    bits  = {2'b00, stop_bit, d, 1'b0};
    nbits = 10;
    if (par_bit) nbits = 10;
`endif
    t_drop = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (BIT_CLK / 2) @(negedge clk);
      if (chk_busy) check($sformatf("busy_bit%0d", i), 16'(bus.rx_busy), 16'd1);
      repeat (BIT_CLK / 2) @(negedge clk);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    int lat;
    // Reset state.
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", 16'(bus.data_out), 16'h00);
    check("rst_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("rst_rx_busy",  16'(bus.rx_busy),  16'd0);
    check("rst_frame_err", 16'(bus.frame_err), 16'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single frame 0xA5 with latency and busy checks.
    push_ev(EV_VALID, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    last_good = 8'hA5;
    drain("drain_a5");
    lat = last_valid_cyc - t_drop;
    check("latency_a5_window", 16'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 16'd1);
    repeat (5) @(negedge clk);
    check("idle_busy_after_a5", 16'(bus.rx_busy), 16'd0);

    // Back-to-back 0x00 then 0xFF (parity bit chosen even in both).
    push_ev(EV_VALID, 8'h00);
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    push_ev(EV_VALID, 8'hFF);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    last_good = 8'hFF;
    drain("drain_00_ff");
    check("data_out_after_ff", 16'(bus.data_out), 16'hFF);

    // Short glitch is rejected.
    repeat (10) @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("glitch_busy_clear", 16'(bus.rx_busy), 16'd0);
    check("glitch_state_idle", 16'(dut.state_q), 16'(IDLE));
    check("glitch_data_kept", 16'(bus.data_out), 16'hFF);

    // Stop bit low followed by a held-low break (0x3C has even weight).
    repeat (10) @(negedge clk);
    push_ev(EV_FERR, last_good);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    check("break_busy_held", 16'(bus.rx_busy), 16'd1);
    check("break_data_kept", 16'(bus.data_out), 16'hFF);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("break_busy_release", 16'(bus.rx_busy), 16'd0);
    drain("drain_ferr");
    push_ev(EV_VALID, 8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    last_good = 8'h81;
    drain("drain_81");

    // Reset in the middle of bit 4 of a frame.
    repeat (10) @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_data_out", 16'(bus.data_out), 16'h00);
    check("midrst_rx_valid", 16'(bus.rx_valid), 16'd0);
    check("midrst_rx_busy", 16'(bus.rx_busy), 16'd0);
    check("midrst_frame_err", 16'(bus.frame_err), 16'd0);
    check("midrst_state", 16'(dut.state_q), 16'(IDLE));
    rst = 1'b0;
    last_good = 8'h00;
    repeat (200) @(negedge clk);
    check("midrst_no_pulse", 16'(exp_q.size()), 16'd0);
    push_ev(EV_VALID, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    last_good = 8'h5A;
    drain("drain_5a");

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity 1 is good, parity 0 is bad.
    push_ev(EV_VALID, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    last_good = 8'h07;
    drain("drain_par_good");
    push_ev(EV_PERR, last_good);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    drain("drain_par_bad");
    check("par_bad_data_kept", 16'(bus.data_out), 16'h07);
`endif

    repeat (20) @(negedge clk);
    check("final_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
